cd_inport_req: RTL and testbench
================================

# cd_inport_req

Input-port requester for the cardinal mesh router; it drives the per-output round-robin arbiters from the input side. It accepts flits from the upstream link into a 2-entry FIFO and computes the dimension-order (X then Y) route of the head flit. It raises a one-hot request toward the chosen output port, holds that request until the arbiter grants it, then pops the flit and presents it, hop-adjusted, on a registered output stage. One instance sits at each router input (N, S, E, W, PE).

## Interface
- DATA_W, 64: flit width; must be ≥ 18.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream flit valid.
- in_data  in  DATA_W  upstream flit. Fields:
  - [17] dir_x: 0 = east, 1 = west.
  - [16] dir_y: 0 = north, 1 = south.
  - [15:12] hop_x, unsigned.
  - [11:8] hop_y, unsigned.
- in_ready  out  1  FIFO can accept; a push occurs when in_valid && in_ready.
- req  out  5  one-hot output request for the head flit; index 0 = N, 1 = S, 2 = E, 3 = W, 4 = PE.
- gnt  in  5  this input's grant bit from each output arbiter (already gated by the arbiter enable).
- out_valid  out  1  forwarded flit valid (one-cycle pulse per flit).
- out_data  out  DATA_W  forwarded flit, hop field updated.
- out_sel  out  5  one-hot output port for out_data; equals the accepted grant.
- err_gnt  out  1  sticky: a grant was seen on a port not requested.

## Operation
- **FIFO**
  - 2 entries, with wr_ptr, rd_ptr and a 2-bit count (0..2).
  - in_ready = (count != 2). It is not pop-aware: when full, a push is refused even in a pop cycle.
  - Push and pop in the same cycle: count unchanged, both pointers advance, and the pointers wrap modulo 2.
- **Route, from the head flit, combinational**
  - hop_x != 0: request E (dir_x = 0) or W (dir_x = 1).
  - else hop_y != 0: request N (dir_y = 0) or S (dir_y = 1).
  - else: request PE.
- **Request**
  - req = route one-hot when count != 0, else 5'b0.
  - req is a function of the head flit only, so it stays stable until that flit is popped. Arbiter fairness depends on this.
- **Accept**
  - acc = |(gnt & req).
  - When acc is true: pop the head and register the outputs.
    - out_data = head flit, with hop_x decremented if the X port was granted, or hop_y decremented if the Y port was granted. PE leaves both hop fields unchanged.
    - out_sel = gnt & req.
    - out_valid = 1.
  - Otherwise out_valid = 0; out_data and out_sel hold their last values.
- **Grant with no matching request**
  - Condition: (gnt & ~req) != 0.
  - Response: no pop, no output, and err_gnt is set until reset. Any matching grant bit received in the same cycle is still accepted.
- gnt = 0 (arbiter enable low): request held, nothing changes.
- Multi-hot gnt masked by the one-hot req: only the requested bit is used.

## Timing
- Reset values:
  - in_ready = 1, req = 0, out_valid = 0, out_data = 0, out_sel = 0, err_gnt = 0.
  - count = 0 and both pointers = 0.
- Reset asserted mid-operation: FIFO contents are discarded and all of the above values apply on the next edge. A grant in the reset cycle is ignored.
- Push to request latency: a flit pushed at edge N is visible on req after edge N if the FIFO was empty.
- Request to grant: the arbiter grant is combinational in the same cycle. The flit is accepted at that edge, and out_valid/out_data/out_sel are valid for exactly the following cycle.
- Throughput: 1 flit/cycle sustained, with back-to-back grants and the next head's req visible the cycle after a pop.
- With continuous upstream traffic and grants every cycle, count remains 1.

## Test plan
- **Reset then single flit.** Push in_data hop_x = 2, dir_x = 0, hop_y = 0 → req = 5'b00100 the next cycle. gnt = 5'b00100 → out_valid pulse with hop_x = 1 and out_sel = 5'b00100; req = 0 afterwards.
- **Route order.** Three flits are pushed; each is granted in turn as its req appears:

  | Flit | Expected req | Forwarded hop fields |
  |---|---|---|
  | hop_x = 0, hop_y = 3, dir_y = 1 | S (5'b00010) | hop_y = 2 |
  | hop_x = 0, hop_y = 0 | PE (5'b10000) | unchanged |
  | hop_x = 1, dir_x = 1 | W (5'b01000) | hop_x = 0 |

- **Full and backpressure.** Push 3 flits with gnt = 0 → in_ready = 0 after 2 pushes and the third is held upstream. One grant → pop; in_ready = 1 the next cycle, and the third push completes.
- **Hold under no grant.** Keep gnt = 0 for 10 cycles → req constant, out_valid = 0, count = 1. Then grant → exactly one out_valid pulse.
- **Wrong grant.** req = E, apply gnt = 5'b00001 → no pop, err_gnt = 1 and sticky. Then gnt = 5'b00100 → accepted; err_gnt is still 1 until reset.
- **Simultaneous push/pop and reset mid-stream.** Stream 8 flits with a grant every cycle → 8 out_valid pulses in order and count stays 1. Assert reset with 2 flits queued → next cycle req = 0, in_ready = 1, out_valid = 0.

Source files
------------

// File: rtl/cd_inport_req_if.sv
// cd_inport_req_if: upstream flit link, arbiter request/grant and forwarded
// flit output of one router input port, bundled as a single interface.
//   master: upstream/arbiter side (drives in_valid, in_data, gnt)
//   slave : input-port requester  (drives in_ready, req, out_*, err_gnt)
interface cd_inport_req_if #(
    parameter int unsigned DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [4:0]        req;
    logic [4:0]        gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_sel;
    logic              err_gnt;

    modport master (
        output in_valid, in_data, gnt,
        input  in_ready, req, out_valid, out_data, out_sel, err_gnt
    );

    modport slave (
        input  in_valid, in_data, gnt,
        output in_ready, req, out_valid, out_data, out_sel, err_gnt
    );
endinterface

// File: rtl/cd_inport_req.sv
// cd_inport_req: input-port requester for the cardinal mesh router.
// Buffers upstream flits in a 2-entry FIFO, routes the head flit X-then-Y,
// holds a one-hot request until granted, then pops the flit and forwards it
// with the traversed hop field decremented on a registered output stage.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus (slave) - in_valid/in_data/in_ready upstream link, req/gnt arbiter
//                 handshake (N,S,E,W,PE = bits 0..4), out_valid/out_data/
//                 out_sel forwarded flit, err_gnt sticky unrequested grant
// DATA_W must be at least 18 to hold the routing fields.
module cd_inport_req #(
    parameter int unsigned DATA_W = 64
) (
    input logic            clk,
    input logic            reset,
    cd_inport_req_if.slave bus
);
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned PORT_W    = 5;
    localparam int unsigned HOP_W     = 4;
    localparam int unsigned DIR_X_BIT = 17;
    localparam int unsigned DIR_Y_BIT = 16;
    localparam int unsigned HOP_X_LSB = 12;
    localparam int unsigned HOP_Y_LSB = 8;
    localparam int unsigned P_N       = 0;
    localparam int unsigned P_S       = 1;
    localparam int unsigned P_E       = 2;
    localparam int unsigned P_W       = 3;
    localparam int unsigned P_PE      = 4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [PORT_W-1:0] out_sel_q;
    logic              err_gnt_q;

    logic [DATA_W-1:0] head_c;
    logic [HOP_W-1:0]  hop_x_c;
    logic [HOP_W-1:0]  hop_y_c;
    logic [PORT_W-1:0] route_c;
    logic [PORT_W-1:0] req_c;
    logic [PORT_W-1:0] hit_c;
    logic              ready_c;
    logic              push_c;
    logic              pop_c;
    logic              bad_c;
    logic [DATA_W-1:0] fwd_c;

    // Dimension-order route of the head flit; depends only on the head so the
    // request is stable until that flit is popped.
    always_comb begin
        head_c  = mem[rd_ptr];
        hop_x_c = head_c[HOP_X_LSB +: HOP_W];
        hop_y_c = head_c[HOP_Y_LSB +: HOP_W];
        route_c = '0;
        if (hop_x_c != '0) begin
            if (head_c[DIR_X_BIT]) route_c[P_W] = 1'b1;
            else                   route_c[P_E] = 1'b1;
        end else if (hop_y_c != '0) begin
            if (head_c[DIR_Y_BIT]) route_c[P_S] = 1'b1;
            else                   route_c[P_N] = 1'b1;
        end else begin
            route_c[P_PE] = 1'b1;
        end
    end

    // Handshake decode; in_ready deliberately ignores a same-cycle pop.
    always_comb begin
        req_c   = (count != 2'd0) ? route_c : '0;
        ready_c = (count != 2'd2);
        push_c  = bus.in_valid && ready_c;
        hit_c   = bus.gnt & req_c;
        pop_c   = |hit_c;
        bad_c   = |(bus.gnt & ~req_c);
    end

    // Forwarded flit: decrement the hop field of the dimension being taken.
    always_comb begin
        fwd_c = head_c;
        if (hit_c[P_E] || hit_c[P_W]) begin
            fwd_c[HOP_X_LSB +: HOP_W] = hop_x_c - 4'd1;
        end else if (hit_c[P_N] || hit_c[P_S]) begin
            fwd_c[HOP_Y_LSB +: HOP_W] = hop_y_c - 4'd1;
        end
    end

    // FIFO storage; contents are don't-care once count is cleared.
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers/occupancy and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            err_gnt_q   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= ~wr_ptr;
            if (pop_c)  rd_ptr <= ~rd_ptr;
            case ({push_c, pop_c})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            out_valid_q <= pop_c;
            if (pop_c) begin
                out_data_q <= fwd_c;
                out_sel_q  <= hit_c;
            end
            if (bad_c) err_gnt_q <= 1'b1;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.req       = req_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.err_gnt   = err_gnt_q;
endmodule

// File: tb/tb_cd_inport_req.sv
// tb_cd_inport_req: scoreboard bench for cd_inport_req. A reference FIFO model
// predicts in_ready/req/err_gnt each cycle; accepted flits push the expected
// forwarded flit and port onto a scoreboard popped on each out_valid pulse.
module tb_cd_inport_req;
    localparam int unsigned DATA_W = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pulses;

    logic [DATA_W-1:0] mq[$];
    logic [68:0]       sb[$];
    logic              m_err;
    logic              m_ovalid;
    logic [DATA_W-1:0] last_d;
    logic [4:0]        last_sel;

    cd_inport_req_if #(.DATA_W(DATA_W)) bus ();

    cd_inport_req #(.DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic dx, input logic dy,
                                             input logic [3:0] hx, input logic [3:0] hy);
        logic [DATA_W-1:0] f;
        f        = {$urandom(), $urandom()};
        f[17]    = dx;
        f[16]    = dy;
        f[15:12] = hx;
        f[11:8]  = hy;
        return f;
    endfunction

    function automatic logic [4:0] model_req();
        logic [DATA_W-1:0] h;
        if (mq.size() == 0) return 5'b00000;
        h = mq[0];
        if (h[15:12] != 4'd0) return h[17] ? 5'b01000 : 5'b00100;
        if (h[11:8] != 4'd0)  return h[16] ? 5'b00010 : 5'b00001;
        return 5'b10000;
    endfunction

    function automatic logic [DATA_W-1:0] adj(input logic [DATA_W-1:0] f, input logic [4:0] sel);
        logic [DATA_W-1:0] r;
        r = f;
        if (sel[2] || sel[3]) r[15:12] = f[15:12] - 4'd1;
        if (sel[0] || sel[1]) r[11:8]  = f[11:8] - 4'd1;
        return r;
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [4:0] g);
        logic [4:0]  er;
        logic [4:0]  hit;
        logic        rdy;
        logic [68:0] e;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.gnt      = g;
        #1;
        er  = model_req();
        rdy = (mq.size() != 2);
        check("in_ready", 64'(bus.in_ready), 64'(rdy));
        check("req", 64'(bus.req), 64'(er));
        check("err_gnt", 64'(bus.err_gnt), 64'(m_err));
        check("out_valid", 64'(bus.out_valid), 64'(m_ovalid));
        if (bus.out_valid && sb.size() != 0) begin
            e        = sb.pop_front();
            last_d   = e[63:0];
            last_sel = e[68:64];
            pulses++;
        end
        check("out_data", bus.out_data, last_d);
        check("out_sel", 64'(bus.out_sel), 64'(last_sel));
        hit      = g & er;
        m_ovalid = |hit;
        if (|(g & ~er)) m_err = 1'b1;
        if (|hit) begin
            sb.push_back({hit, adj(mq[0], hit)});
            void'(mq.pop_front());
        end
        if (v && rdy) mq.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(1'b0, 1'b0, 4'd1, 4'd0);
        bus.gnt      = 5'b11111;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.gnt      = 5'b00000;
        mq.delete();
        sb.delete();
        m_err    = 1'b0;
        m_ovalid = 1'b0;
        last_d   = '0;
        last_sel = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] f;
        int p0;
        checks = 0;
        errors = 0;
        pulses = 0;
        reset  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.gnt      = '0;
        @(posedge clk);
        #1;
        do_reset();
        step(1'b0, '0, 5'b0);

        // single flit east, two hops
        step(1'b1, mk(1'b0, 1'b0, 4'd2, 4'd0), 5'b0);
        step(1'b0, '0, 5'b00100);
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b0);

        // route order: S, PE, W, each granted as it appears
        step(1'b1, mk(1'b0, 1'b1, 4'd0, 4'd3), 5'b0);
        step(1'b1, mk(1'b0, 1'b0, 4'd0, 4'd0), model_req());
        step(1'b1, mk(1'b1, 1'b0, 4'd1, 4'd0), model_req());
        step(1'b0, '0, model_req());
        step(1'b0, '0, 5'b0);

        // full and backpressure: third flit held until space frees
        f = mk(1'b0, 1'b1, 4'd0, 4'd2);
        step(1'b1, mk(1'b1, 1'b0, 4'd3, 4'd1), 5'b0);
        step(1'b1, mk(1'b0, 1'b0, 4'd0, 4'd1), 5'b0);
        step(1'b1, f, 5'b0);
        step(1'b1, f, model_req());
        step(1'b1, f, 5'b0);
        step(1'b0, '0, model_req());
        step(1'b0, '0, model_req());
        step(1'b0, '0, 5'b0);

        // hold under no grant, then a single accept
        step(1'b1, mk(1'b1, 1'b1, 4'd0, 4'd5), 5'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 5'b0);
        step(1'b0, '0, model_req());
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b0);

        // wrong grant, sticky error, then matching and multi-hot grants
        step(1'b1, mk(1'b0, 1'b0, 4'd4, 4'd0), 5'b0);
        step(1'b0, '0, 5'b00001);
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b00100);
        step(1'b1, mk(1'b0, 1'b0, 4'd1, 4'd1), 5'b0);
        step(1'b0, '0, 5'b10110);
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b0);

        // 8-flit stream with simultaneous push/pop every cycle
        p0 = pulses;
        step(1'b1, mk(1'($urandom()), 1'($urandom()), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))), 5'b0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, mk(1'($urandom()), 1'($urandom()), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))), model_req());
        end
        step(1'b0, '0, model_req());
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b0);
        check("stream_pulses", 64'(pulses - p0), 64'd8);

        // reset with two flits queued and a grant asserted
        step(1'b1, mk(1'b0, 1'b0, 4'd2, 4'd0), 5'b0);
        step(1'b1, mk(1'b1, 1'b0, 4'd0, 4'd2), 5'b0);
        do_reset();
        step(1'b0, '0, 5'b0);
        step(1'b0, '0, 5'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
